// File: rtl/game_round_ctrl.sv
// -----------------------------------------------------------------------------
// game_round_ctrl
// Round sequencer for a memory game: a random four-digit BCD target is loaded,
// shown for a fixed time, then the player keys in four digits against an entry
// timeout. The entry is compared with the target, score/lives are updated, the
// result is held, and the game either loops to the next round or ends.
//
// Parameters
//   SHOW_CYCLES    cycles the target is displayed
//   ENTRY_TIMEOUT  cycles allowed for entry before a forced failure
//   RESULT_CYCLES  cycles the result is held
//   LIVES          wrong answers allowed per game (1-3)
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-low reset
//   start      in   single-cycle pulse that begins a game (IDLE/OVER only)
//   rand_val   in   16  four BCD digits, valid while rand_req is high
//   rand_req   out  request for a new random value (LOAD only)
//   digit      in   4   keypad digit
//   digit_vld  in   strobe qualifying digit
//   clear      in   discard the partial entry
//   disp_val   out  16  four BCD digits to the display
//   disp_en    out  display enable, 1 = show
//   entry_cnt  out  3   digits accepted in the current entry
//   score      out  8   correct rounds this game
//   lives      out  2   remaining lives
//   correct    out  result of the last check
//   game_over  out  game finished flag
//   state      out  3   IDLE=0 LOAD=1 SHOW=2 ENTRY=3 CHECK=4 RESULT=5 OVER=6
// -----------------------------------------------------------------------------
module game_round_ctrl #(
  parameter int SHOW_CYCLES   = 100000000,
  parameter int ENTRY_TIMEOUT = 500000000,
  parameter int RESULT_CYCLES = 50000000,
  parameter int LIVES         = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] rand_val,
  output logic        rand_req,
  input  logic [3:0]  digit,
  input  logic        digit_vld,
  input  logic        clear,
  output logic [15:0] disp_val,
  output logic        disp_en,
  output logic [2:0]  entry_cnt,
  output logic [7:0]  score,
  output logic [1:0]  lives,
  output logic        correct,
  output logic        game_over,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SHOW   = 3'd2,
    ST_ENTRY  = 3'd3,
    ST_CHECK  = 3'd4,
    ST_RESULT = 3'd5,
    ST_OVER   = 3'd6
  } state_t;

  localparam logic [31:0] LP_SHOW_LAST   = 32'(SHOW_CYCLES - 1);
  localparam logic [31:0] LP_ENTRY_LAST  = 32'(ENTRY_TIMEOUT - 1);
  localparam logic [31:0] LP_RESULT_LAST = 32'(RESULT_CYCLES - 1);
  localparam logic [1:0]  LP_LIVES       = 2'(LIVES);

  // Score shown on the game-over screen: two BCD digits, clamped at 99.
  function automatic logic [7:0] score_to_bcd(input logic [7:0] s);
    logic [3:0] tens;
    logic [3:0] ones;
    if (s < 8'd100) begin
      tens = 4'(s / 8'd10);
      ones = 4'(s % 8'd10);
      score_to_bcd = {tens, ones};
    end else begin
      score_to_bcd = 8'h99;
    end
  endfunction

  state_t      r_state;
  logic [15:0] r_target;
  logic [15:0] r_entry;
  logic [2:0]  r_entry_cnt;
  logic [7:0]  r_score;
  logic [1:0]  r_lives;
  logic        r_correct;
  logic        r_timeout;
  logic [31:0] r_cnt;
  logic        r_rand_req;
  logic        r_disp_en;
  logic [15:0] r_disp_val;
  logic        r_game_over;

  state_t      w_state_nxt;
  logic [15:0] w_target_nxt;
  logic [15:0] w_entry_nxt;
  logic [2:0]  w_entry_cnt_nxt;
  logic [7:0]  w_score_nxt;
  logic [1:0]  w_lives_nxt;
  logic        w_correct_nxt;
  logic        w_timeout_nxt;
  logic [31:0] w_cnt_nxt;
  logic        w_rand_req_nxt;
  logic        w_disp_en_nxt;
  logic [15:0] w_disp_val_nxt;
  logic        w_game_over_nxt;
  logic        w_digit_ok;
  logic        w_match;

  // Next-state, datapath and output decode for the round sequencer.
  always_comb begin
    w_state_nxt     = r_state;
    w_target_nxt    = r_target;
    w_entry_nxt     = r_entry;
    w_entry_cnt_nxt = r_entry_cnt;
    w_score_nxt     = r_score;
    w_lives_nxt     = r_lives;
    w_correct_nxt   = r_correct;
    w_timeout_nxt   = r_timeout;
    w_cnt_nxt       = 32'd0;
    w_rand_req_nxt  = 1'b0;
    w_disp_en_nxt   = 1'b0;
    w_disp_val_nxt  = 16'h0000;
    w_game_over_nxt = 1'b0;
    w_digit_ok      = digit_vld && (digit <= 4'd9);
    w_match         = 1'b0;

    case (r_state)
      ST_IDLE, ST_OVER: begin
        if (start) begin
          w_state_nxt = ST_LOAD;
          w_score_nxt = 8'd0;
          w_lives_nxt = LP_LIVES;
        end else begin
          w_state_nxt = r_state;
        end
      end
      ST_LOAD: begin
        w_target_nxt = rand_val;
        w_state_nxt  = ST_SHOW;
      end
      ST_SHOW: begin
        if (r_cnt == LP_SHOW_LAST) begin
          w_state_nxt     = ST_ENTRY;
          w_entry_nxt     = 16'h0000;
          w_entry_cnt_nxt = 3'd0;
          w_timeout_nxt   = 1'b0;
        end else begin
          w_state_nxt = ST_SHOW;
        end
      end
      ST_ENTRY: begin
        // clear has priority over a simultaneous digit
        if (clear) begin
          w_entry_nxt     = 16'h0000;
          w_entry_cnt_nxt = 3'd0;
        end else if (w_digit_ok) begin
          w_entry_nxt     = {r_entry[11:0], digit};
          w_entry_cnt_nxt = r_entry_cnt + 3'd1;
        end else begin
          w_entry_nxt = r_entry;
        end
        // a 4th digit on the expiry cycle beats the timeout
        if (!clear && w_digit_ok && (r_entry_cnt == 3'd3)) begin
          w_state_nxt = ST_CHECK;
        end else if (r_cnt == LP_ENTRY_LAST) begin
          w_state_nxt   = ST_CHECK;
          w_timeout_nxt = 1'b1;
        end else begin
          w_state_nxt = ST_ENTRY;
        end
      end
      ST_CHECK: begin
        w_match       = (r_entry == r_target) && !r_timeout;
        w_correct_nxt = w_match;
        if (w_match) begin
          if (r_score != 8'hFF) begin
            w_score_nxt = r_score + 8'd1;
          end else begin
            w_score_nxt = r_score;
          end
        end else if (r_lives != 2'd0) begin
          w_lives_nxt = r_lives - 2'd1;
        end else begin
          w_lives_nxt = r_lives;
        end
        w_state_nxt = ST_RESULT;
      end
      ST_RESULT: begin
        if (r_cnt == LP_RESULT_LAST) begin
          if (r_lives == 2'd0) begin
            w_state_nxt = ST_OVER;
          end else begin
            w_state_nxt = ST_LOAD;
          end
        end else begin
          w_state_nxt = ST_RESULT;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // timers restart on every state change and only run in timed states
    if (w_state_nxt != r_state) begin
      w_cnt_nxt = 32'd0;
    end else if ((r_state == ST_SHOW) || (r_state == ST_ENTRY) || (r_state == ST_RESULT)) begin
      w_cnt_nxt = r_cnt + 32'd1;
    end else begin
      w_cnt_nxt = 32'd0;
    end

    // outputs are decoded from next-state values so they register in step with the state
    w_rand_req_nxt  = (w_state_nxt == ST_LOAD);
    w_game_over_nxt = (w_state_nxt == ST_OVER);
    case (w_state_nxt)
      ST_SHOW, ST_RESULT: begin
        w_disp_en_nxt  = 1'b1;
        w_disp_val_nxt = w_target_nxt;
      end
      ST_ENTRY, ST_CHECK: begin
        w_disp_en_nxt  = 1'b1;
        w_disp_val_nxt = w_entry_nxt;
      end
      ST_OVER: begin
        w_disp_en_nxt  = 1'b1;
        w_disp_val_nxt = {8'h00, score_to_bcd(w_score_nxt)};
      end
      default: begin
        w_disp_en_nxt  = 1'b0;
        w_disp_val_nxt = 16'h0000;
      end
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_target    <= 16'h0000;
      r_entry     <= 16'h0000;
      r_entry_cnt <= 3'd0;
      r_score     <= 8'd0;
      r_lives     <= LP_LIVES;
      r_correct   <= 1'b0;
      r_timeout   <= 1'b0;
      r_cnt       <= 32'd0;
      r_rand_req  <= 1'b0;
      r_disp_en   <= 1'b0;
      r_disp_val  <= 16'h0000;
      r_game_over <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_target    <= w_target_nxt;
      r_entry     <= w_entry_nxt;
      r_entry_cnt <= w_entry_cnt_nxt;
      r_score     <= w_score_nxt;
      r_lives     <= w_lives_nxt;
      r_correct   <= w_correct_nxt;
      r_timeout   <= w_timeout_nxt;
      r_cnt       <= w_cnt_nxt;
      r_rand_req  <= w_rand_req_nxt;
      r_disp_en   <= w_disp_en_nxt;
      r_disp_val  <= w_disp_val_nxt;
      r_game_over <= w_game_over_nxt;
    end
  end

  assign rand_req  = r_rand_req;
  assign disp_val  = r_disp_val;
  assign disp_en   = r_disp_en;
  assign entry_cnt = r_entry_cnt;
  assign score     = r_score;
  assign lives     = r_lives;
  assign correct   = r_correct;
  assign game_over = r_game_over;
  assign state     = r_state;

endmodule

// File: tb/tb_game_round_ctrl.sv
// -----------------------------------------------------------------------------
// tb_game_round_ctrl
// Directed and randomised rounds of the memory game. A behavioural model keeps
// the entered digits as a queue and the game score/lives as integers; every
// observation is compared against it with immediate assertions.
// -----------------------------------------------------------------------------
module tb_game_round_ctrl;

  localparam int P_SHOW  = 4;
  localparam int P_ET    = 20;
  localparam int P_RC    = 2;
  localparam int P_LIVES = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] rand_val = 16'h0000;
  logic [3:0]  digit = 4'd0;
  logic        digit_vld = 1'b0;
  logic        clear = 1'b0;
  logic        rand_req;
  logic [15:0] disp_val;
  logic        disp_en;
  logic [2:0]  entry_cnt;
  logic [7:0]  score;
  logic [1:0]  lives;
  logic        correct;
  logic        game_over;
  logic [2:0]  state;

  int   checks = 0;
  int   errors = 0;
  int   m_score;
  int   m_lives;
  logic m_correct;

  typedef struct {
    logic       vld;
    logic       clr;
    logic [3:0] d;
  } op_t;

  op_t ops[$];

  game_round_ctrl #(
    .SHOW_CYCLES   (P_SHOW),
    .ENTRY_TIMEOUT (P_ET),
    .RESULT_CYCLES (P_RC),
    .LIVES         (P_LIVES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .rand_val  (rand_val),
    .rand_req  (rand_req),
    .digit     (digit),
    .digit_vld (digit_vld),
    .clear     (clear),
    .disp_val  (disp_val),
    .disp_en   (disp_en),
    .entry_cnt (entry_cnt),
    .score     (score),
    .lives     (lives),
    .correct   (correct),
    .game_over (game_over),
    .state     (state)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int bcd_of(input int s);
    if (s < 100) return (s / 10) * 16 + (s % 10);
    return 'h99;
  endfunction

  function automatic logic [15:0] rand_bcd();
    logic [15:0] v;
    v = 16'h0000;
    for (int i = 0; i < 4; i++) v = 16'(v * 16 + $urandom_range(0, 9));
    return v;
  endfunction

  task automatic check_reset(input string tag);
    chk({tag, "_state"},     32'(state),     32'd0);
    chk({tag, "_rand_req"},  32'(rand_req),  32'd0);
    chk({tag, "_disp_en"},   32'(disp_en),   32'd0);
    chk({tag, "_disp_val"},  32'(disp_val),  32'd0);
    chk({tag, "_entry_cnt"}, 32'(entry_cnt), 32'd0);
    chk({tag, "_score"},     32'(score),     32'd0);
    chk({tag, "_lives"},     32'(lives),     32'(P_LIVES));
    chk({tag, "_correct"},   32'(correct),   32'd0);
    chk({tag, "_game_over"}, 32'(game_over), 32'd0);
  endtask

  task automatic new_game_model();
    m_score = 0;
    m_lives = P_LIVES;
  endtask

  // builds a random keypad sequence that is mostly the target's digits
  task automatic gen_random_ops(input logic [15:0] tgt);
    int  p;
    int  sel;
    op_t op;
    ops.delete();
    p = 0;
    for (int n = 0; n < P_ET - 1 && p < 4; n++) begin
      sel = $urandom_range(0, 9);
      op = '{vld: 1'b0, clr: 1'b0, d: 4'd0};
      if (sel <= 5) begin
        op.vld = 1'b1; op.d = 4'(tgt >> (12 - 4 * p)); p++;
      end else if (sel == 6) begin
        op.vld = 1'b1; op.d = 4'($urandom_range(0, 9)); p++;
      end else if (sel == 7) begin
        op.vld = 1'b1; op.d = 4'($urandom_range(10, 15));
      end else if (sel == 9) begin
        op.clr = 1'b1; op.vld = 1'b1; op.d = 4'($urandom_range(0, 9)); p = 0;
      end
      ops.push_back(op);
    end
  endtask

  task automatic push_digits(input int d0, input int d1, input int d2, input int d3, input int n);
    int d[4];
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    for (int i = 0; i < n; i++) ops.push_back('{vld: 1'b1, clr: 1'b0, d: 4'(d[i])});
  endtask

  // one full round, entered with LOAD observed; leaves with LOAD or OVER observed
  task automatic play_round(input logic [15:0] tgt, input logic poke);
    op_t  op;
    int   q[$];
    int   ent;
    logic done;
    logic exp_ok;
    chk("load_state",   32'(state),    32'd1);
    chk("load_rand_req", 32'(rand_req), 32'd1);
    chk("load_disp_en", 32'(disp_en),  32'd0);
    chk("load_correct_held", 32'(correct), 32'(m_correct));
    rand_val = tgt;
    tick();
    rand_val = 16'($urandom);
    for (int i = 0; i < P_SHOW; i++) begin
      chk("show_state",    32'(state),    32'd2);
      chk("show_disp_val", 32'(disp_val), 32'(tgt));
      chk("show_disp_en",  32'(disp_en),  32'd1);
      chk("show_rand_req", 32'(rand_req), 32'd0);
      if (poke && i == 1) begin
        start = 1'b1; digit = 4'd5; digit_vld = 1'b1;
      end
      tick();
      start = 1'b0; digit_vld = 1'b0;
    end
    chk("entry_state_first", 32'(state),     32'd3);
    chk("entry_cnt_first",   32'(entry_cnt), 32'd0);
    chk("entry_disp_first",  32'(disp_val),  32'd0);
    done = 1'b0;
    for (int k = 0; k < P_ET && !done; k++) begin
      if (ops.size() > 0) op = ops.pop_front();
      else op = '{vld: 1'b0, clr: 1'b0, d: 4'd0};
      digit_vld = op.vld; clear = op.clr; digit = op.d;
      tick();
      digit_vld = 1'b0; clear = 1'b0;
      if (op.clr) q.delete();
      else if (op.vld && op.d <= 4'd9) q.push_back(int'(op.d));
      if (q.size() == 4) begin
        done = 1'b1;
        chk("entry_to_check", 32'(state),     32'd4);
        chk("entry_cnt_full", 32'(entry_cnt), 32'd4);
      end else if (k == P_ET - 1) begin
        chk("timeout_to_check", 32'(state), 32'd4);
      end else begin
        ent = 0;
        foreach (q[j]) ent = ent * 16 + q[j];
        chk("entry_state", 32'(state),     32'd3);
        chk("entry_cnt",   32'(entry_cnt), 32'(q.size()));
        chk("entry_disp",  32'(disp_val),  32'(ent));
      end
    end
    ent = 0;
    foreach (q[j]) ent = ent * 16 + q[j];
    exp_ok = (q.size() == 4) && (ent == int'(tgt));
    ops.delete();
    tick();
    if (exp_ok) begin
      m_correct = 1'b1;
      if (m_score < 255) m_score++;
    end else begin
      m_correct = 1'b0;
      m_lives--;
    end
    for (int r = 0; r < P_RC; r++) begin
      chk("result_state",   32'(state),    32'd5);
      chk("result_correct", 32'(correct),  32'(m_correct));
      chk("result_score",   32'(score),    32'(m_score));
      chk("result_lives",   32'(lives),    32'(m_lives));
      chk("result_disp",    32'(disp_val), 32'(tgt));
      chk("result_disp_en", 32'(disp_en),  32'd1);
      if (r == 0) start = 1'b1;
      tick();
      start = 1'b0;
    end
    if (m_lives == 0) begin
      chk("over_state",     32'(state),     32'd6);
      chk("over_game_over", 32'(game_over), 32'd1);
      chk("over_disp_en",   32'(disp_en),   32'd1);
      chk("over_disp_val",  32'(disp_val),  32'(bcd_of(m_score)));
    end else begin
      chk("next_load_state", 32'(state),     32'd1);
      chk("next_game_over",  32'(game_over), 32'd0);
    end
  endtask

  initial begin
    logic [15:0] tgt;
    m_correct = 1'b0;
    new_game_model();
    #12;
    check_reset("por");

    // start coincident with the first edge after reset release
    @(negedge clk);
    rst = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;

    // game 1: correct, wrong, clear/invalid-digit round, then random rounds
    push_digits(3, 7, 1, 9, 4);
    play_round(16'h3719, 1'b0);
    push_digits(0, 4, 2, 8, 4);
    play_round(16'h0420, 1'b0);
    push_digits(5, 6, 0, 0, 2);
    ops.push_back('{vld: 1'b1, clr: 1'b1, d: 4'd9});
    ops.push_back('{vld: 1'b1, clr: 1'b0, d: 4'hA});
    push_digits(1, 2, 3, 4, 4);
    play_round(16'h1234, 1'b1);
    for (int r = 0; r < 6 && m_lives > 0; r++) begin
      tgt = rand_bcd();
      gen_random_ops(tgt);
      play_round(tgt, 1'b0);
    end
    while (m_lives > 0) begin
      play_round(rand_bcd(), 1'b0);
    end

    // restart from OVER
    start = 1'b1;
    tick();
    start = 1'b0;
    new_game_model();
    chk("restart_game_over", 32'(game_over), 32'd0);
    chk("restart_score",     32'(score),     32'd0);
    chk("restart_lives",     32'(lives),     32'(P_LIVES));

    // game 2: 4th digit on the last entry cycle, partial-match timeout, empty timeout
    tgt = rand_bcd();
    for (int i = 0; i < P_ET - 4; i++) ops.push_back('{vld: 1'b0, clr: 1'b0, d: 4'd0});
    push_digits(int'(tgt[15:12]), int'(tgt[11:8]), int'(tgt[7:4]), int'(tgt[3:0]), 4);
    play_round(tgt, 1'b0);
    push_digits(1, 2, 0, 0, 2);
    play_round(16'h0012, 1'b0);
    play_round(rand_bcd(), 1'b0);

    // asynchronous reset in the middle of SHOW
    start = 1'b1;
    tick();
    start = 1'b0;
    rand_val = 16'h5555;
    tick();
    tick();
    #3 rst = 1'b0;
    #1 check_reset("rst_show");
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("post_rst_idle", 32'(state), 32'd0);

    // asynchronous reset in the middle of ENTRY
    start = 1'b1;
    tick();
    start = 1'b0;
    rand_val = 16'h8642;
    tick();
    for (int i = 0; i < P_SHOW; i++) tick();
    digit = 4'd7; digit_vld = 1'b1;
    tick();
    digit_vld = 1'b0;
    chk("pre_rst_entry_cnt", 32'(entry_cnt), 32'd1);
    #2 rst = 1'b0;
    #1 check_reset("rst_entry");
    @(negedge clk);
    rst = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    m_correct = 1'b0;
    new_game_model();
    push_digits(2, 4, 6, 8, 4);
    play_round(16'h2468, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
